// File: rtl/ifu_pkg.sv
// Shared types, constants and bus-width macros for the instruction fetch unit.
// The macros mirror the core-wide defines header so ports read the same as in idu/exu.
`ifndef YSYX_23060251_IFU_DEFS
`define YSYX_23060251_IFU_DEFS
`define YSYX_23060251_PC_BUS    [63:0]
`define YSYX_23060251_INST_BUS  [31:0]
`define YSYX_23060251_RESET_PC  64'h8000_0000
`define YSYX_23060251_NOP_INST  32'h0000_0013
`endif

package ifu_pkg;
    localparam logic [63:0] IFU_RESET_PC = `YSYX_23060251_RESET_PC;
    localparam logic [31:0] IFU_NOP_INST = `YSYX_23060251_NOP_INST;

    // Contents of the output register handed to idu.
    typedef struct packed {
        logic `YSYX_23060251_INST_BUS inst;
        logic `YSYX_23060251_PC_BUS   pc;
        logic                         fault;
    } inst_pkt_t;

    function automatic logic [63:0] align_pc(input logic [63:0] a);
        return {a[63:2], 2'b00};
    endfunction
endpackage

// File: rtl/ifu_if.sv
// Fetch-unit bus bundle: imem request/response, idu output handshake and exu redirect.
interface ifu_if;
    logic                         req_valid_o;
    logic                         req_ready_i;
    logic `YSYX_23060251_PC_BUS   req_addr_o;
    logic                         rsp_valid_i;
    logic `YSYX_23060251_INST_BUS rsp_data_i;
    logic                         rsp_err_i;
    logic                         inst_valid_o;
    logic                         inst_ready_i;
    logic `YSYX_23060251_INST_BUS inst_o;
    logic `YSYX_23060251_PC_BUS   pc_o;
    logic                         fault_o;
    logic                         redirect_valid_i;
    logic `YSYX_23060251_PC_BUS   redirect_pc_i;
    logic [63:0]                  fetch_cnt_o;

    modport master (
        output req_valid_o, req_addr_o, inst_valid_o, inst_o, pc_o, fault_o, fetch_cnt_o,
        input  req_ready_i, rsp_valid_i, rsp_data_i, rsp_err_i, inst_ready_i,
               redirect_valid_i, redirect_pc_i
    );

    modport slave (
        input  req_valid_o, req_addr_o, inst_valid_o, inst_o, pc_o, fault_o, fetch_cnt_o,
        output req_ready_i, rsp_valid_i, rsp_data_i, rsp_err_i, inst_ready_i,
               redirect_valid_i, redirect_pc_i
    );
endinterface

// File: rtl/ifu_pc_reg.sv
// Fetch PC register: reset value, sequential +4 advance, redirect override (word aligned).
module ifu_pc_reg
    import ifu_pkg::*;
#(
    parameter logic [63:0] RESET_PC = IFU_RESET_PC
) (
    input  logic                       clk_i,
    input  logic                       rst_n_i,
    input  logic                       adv_i,
    input  logic                       redir_i,
    input  logic `YSYX_23060251_PC_BUS redir_pc_i,
    output logic `YSYX_23060251_PC_BUS pc_o
);
    // Redirect wins over a same-cycle advance; +4 wraps naturally at 2^64.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i)     pc_o <= RESET_PC;
        else if (redir_i) pc_o <= align_pc(redir_pc_i);
        else if (adv_i)   pc_o <= pc_o + 64'd4;
    end
endmodule

// File: rtl/ifu.sv
// Instruction fetch stage: single outstanding imem request, registered output to idu,
// redirect/flush from exu. Next PC is always PC+4 absent a redirect.
module ifu
    import ifu_pkg::*;
#(
    parameter logic [63:0] RESET_PC = `YSYX_23060251_RESET_PC
) (
    input  logic  clk_i,
    input  logic  rst_n_i,
    ifu_if.master bus
);
    typedef enum logic [1:0] {S_REQ, S_WAIT, S_HOLD, S_DROP} state_t;

    state_t      state, state_nxt;
    logic        started;
    logic        req_valid;
    logic        hs;
    logic        redir;
    logic        rsp_take;
    logic        out_vld;
    inst_pkt_t   out_q;
    logic [63:0] cnt;
    logic `YSYX_23060251_PC_BUS pc;

    assign redir    = bus.redirect_valid_i;
    assign hs       = req_valid & bus.req_ready_i;
    assign rsp_take = (state == S_WAIT) & bus.rsp_valid_i & ~redir;

    ifu_pc_reg #(.RESET_PC(RESET_PC)) u_pc (
        .clk_i      (clk_i),
        .rst_n_i    (rst_n_i),
        .adv_i      (rsp_take),
        .redir_i    (redir),
        .redir_pc_i (bus.redirect_pc_i),
        .pc_o       (pc)
    );

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) state <= S_REQ;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_REQ: begin
                // A request accepted alongside a redirect is for the old PC; its reply must be dropped.
                if (redir)   state_nxt = hs ? S_DROP : S_REQ;
                else if (hs) state_nxt = S_WAIT;
            end
            S_WAIT: begin
                if (bus.rsp_valid_i) state_nxt = redir ? S_REQ : S_HOLD;
                else if (redir)      state_nxt = S_DROP;
            end
            S_HOLD:  if (redir || bus.inst_ready_i) state_nxt = S_REQ;
            S_DROP:  if (bus.rsp_valid_i)           state_nxt = S_REQ;
            default: state_nxt = S_REQ;
        endcase
    end

    // Requests are held off for the first cycle after reset so req_valid_o reads 0 during reset.
    always_comb begin
        req_valid = (state == S_REQ) & started;
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            started <= 1'b0;
            out_vld <= 1'b0;
            out_q   <= '0;
            cnt     <= '0;
        end else begin
            started <= 1'b1;
            if (redir) begin
                out_vld <= 1'b0;
            end else if (rsp_take) begin
                out_vld     <= 1'b1;
                out_q.inst  <= bus.rsp_err_i ? IFU_NOP_INST : bus.rsp_data_i;
                out_q.pc    <= pc;
                out_q.fault <= bus.rsp_err_i;
            end else if (out_vld && bus.inst_ready_i) begin
                out_vld <= 1'b0;
                cnt     <= cnt + 64'd1;
            end
        end
    end

    assign bus.req_valid_o  = req_valid;
    assign bus.req_addr_o   = pc;
    assign bus.inst_valid_o = out_vld;
    assign bus.inst_o       = out_q.inst;
    assign bus.pc_o         = out_q.pc;
    assign bus.fault_o      = out_q.fault;
    assign bus.fetch_cnt_o  = cnt;
endmodule

// File: tb/tb_ifu.sv
// Randomized bench for ifu: imem/exu/idu stimulus plus a transaction-level fetch model
// feeding a scoreboard that a separate monitor drains on each idu-side output.
module tb_ifu;
    import ifu_pkg::*;

    localparam logic [63:0] RPC = 64'h8000_0000;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    ifu_if b();

    ifu #(.RESET_PC(RPC)) dut (
        .clk_i   (clk),
        .rst_n_i (rst_n),
        .bus     (b)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] inst;
        logic [63:0] pc;
        logic        fault;
    } exp_t;

    exp_t        exp_q[$];
    int          checks    = 0;
    int          failures  = 0;
    int          delivered = 0;
    logic [63:0] model_pc;
    logic [63:0] model_cnt;

    // imem model state: at most one accepted, unanswered request
    logic        outst;
    logic        ost_stale;
    logic [63:0] ost_addr;
    int          ost_wait;

    function automatic logic [31:0] mem_word(input logic [63:0] a);
        return (a[33:2] * 32'h9E37_79B1) ^ a[63:32] ^ 32'hA5A5_0000;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic drive_idle();
        b.req_ready_i      = 1'b0;
        b.rsp_valid_i      = 1'b0;
        b.rsp_data_i       = '0;
        b.rsp_err_i        = 1'b0;
        b.inst_ready_i     = 1'b0;
        b.redirect_valid_i = 1'b0;
        b.redirect_pc_i    = '0;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_req_valid"},  64'(b.req_valid_o),  64'd0);
        chk({tag, "_inst_valid"}, 64'(b.inst_valid_o), 64'd0);
        chk({tag, "_inst"},       64'(b.inst_o),       64'd0);
        chk({tag, "_pc"},         b.pc_o,              64'd0);
        chk({tag, "_fault"},      64'(b.fault_o),      64'd0);
        chk({tag, "_fetch_cnt"},  b.fetch_cnt_o,       64'd0);
    endtask

    task automatic do_reset(input string tag);
        @(negedge clk);
        rst_n = 1'b0;
        drive_idle();
        outst     = 1'b0;
        ost_stale = 1'b0;
        exp_q.delete();
        model_pc  = RPC;
        model_cnt = '0;
        #1 chk_reset_vals(tag);
        repeat (2) @(negedge clk);
        chk_reset_vals({tag, "_held"});
        rst_n = 1'b1;
        @(negedge clk);
        #1;
        chk({tag, "_req_valid_after"}, 64'(b.req_valid_o), 64'd1);
        chk({tag, "_req_addr_after"},  b.req_addr_o,       RPC);
    endtask

    // One cycle of stimulus; the model updates for what the coming rising edge will do.
    task automatic step(input int p_rdy, input int p_irdy, input int p_redir,
                        input int p_err, input int max_lat);
        logic        fire, red, hs;
        logic [63:0] rpc;
        logic [31:0] r;
        exp_t        e;
        @(negedge clk);
        fire = outst && (ost_wait == 0);
        if (outst && ost_wait > 0) ost_wait--;
        red = ($urandom_range(99) < p_redir);
        r   = $urandom;
        case ($urandom_range(2))
            0:       rpc = 64'h8000_0000 + 64'(r & 32'h0000_0FFF);
            1:       rpc = 64'hFFFF_FFFF_FFFF_FFF0 | 64'(r & 32'hF);
            default: rpc = {32'h0, r};
        endcase
        b.rsp_valid_i      = fire;
        b.rsp_data_i       = fire ? mem_word(ost_addr) : $urandom;
        b.rsp_err_i        = fire && ($urandom_range(99) < p_err);
        b.redirect_valid_i = red;
        b.redirect_pc_i    = red ? rpc : {32'h0, $urandom};
        b.req_ready_i      = ($urandom_range(99) < p_rdy);
        b.inst_ready_i     = ($urandom_range(99) < p_irdy);
        hs = b.req_valid_o && b.req_ready_i;
        if (fire) begin
            outst = 1'b0;
            if (!(ost_stale || red)) begin
                e.inst  = b.rsp_err_i ? 32'h0000_0013 : mem_word(ost_addr);
                e.pc    = ost_addr;
                e.fault = b.rsp_err_i;
                exp_q.push_back(e);
                model_pc = model_pc + 64'd4;
            end
        end else if (outst && red) begin
            ost_stale = 1'b1;
        end
        if (hs) begin
            chk("req_addr", b.req_addr_o, model_pc);
            outst     = 1'b1;
            ost_stale = red;
            ost_addr  = model_pc;
            ost_wait  = $urandom_range(max_lat);
        end
        if (red) begin
            model_pc = rpc & ~64'd3;
            exp_q.delete();
        end
    endtask

    // Monitor: compares whatever ifu presents to idu against the scoreboard.
    initial begin
        forever begin
            @(negedge clk);
            #1;
            if (rst_n && b.inst_valid_o && !b.redirect_valid_i) begin
                chk("no_req_in_hold", 64'(b.req_valid_o), 64'd0);
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_inst actual inst_valid=1 pc=%h expected inst_valid=0",
                             b.pc_o);
                end else begin
                    chk("inst",  64'(b.inst_o),  64'(exp_q[0].inst));
                    chk("pc",    b.pc_o,         exp_q[0].pc);
                    chk("fault", 64'(b.fault_o), 64'(exp_q[0].fault));
                    if (b.inst_ready_i) begin
                        chk("fetch_cnt", b.fetch_cnt_o, model_cnt);
                        model_cnt = model_cnt + 64'd1;
                        delivered++;
                        void'(exp_q.pop_front());
                    end
                end
            end
        end
    end

    initial begin
        drive_idle();
        outst     = 1'b0;
        ost_stale = 1'b0;
        ost_addr  = '0;
        ost_wait  = 0;
        model_pc  = RPC;
        model_cnt = '0;
        do_reset("reset");
        // zero-latency imem, always-ready idu
        repeat (30)  step(100, 100, 0, 0, 0);
        // idu stalled: output must hold, no new request
        repeat (20)  step(100, 0, 0, 0, 1);
        repeat (400) step(60, 60, 10, 10, 3);
        repeat (300) step(100, 100, 25, 5, 0);
        // reset while a request is in flight
        for (int i = 0; i < 20 && !outst; i++) step(100, 100, 0, 0, 3);
        chk("reset_mid_in_flight", 64'(outst), 64'd1);
        do_reset("reset_mid");
        repeat (400) step(70, 50, 8, 15, 2);
        @(negedge clk);
        drive_idle();
        checks++;
        if (delivered < 100) begin
            failures++;
            $display("FAIL progress actual=%0d expected>=100", delivered);
        end
        repeat (2) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
